// File: rtl/delay_sram_ctrl.sv
// Circular sample-history controller on an asynchronous 16-bit SRAM.
// Writes new samples at the ring head and serves delayed reads relative to it.
module delay_sram_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 13,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd,
    input  logic [ADDR_WIDTH-1:0]      offset,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       read_finish,
    output logic                       busy,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    inout  wire  [DATA_WIDTH-1:0]      SRAM_DQ,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_OE_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N
);

    localparam int RW = ADDR_WIDTH - 1;
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] WE_END   = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

    state_t                       state_q;
    logic [CW-1:0]                cnt_q;
    logic [RW-1:0]                wptr_q;
    logic                         wrPend_q;
    logic                         rdPend_q;
    logic [DATA_WIDTH-1:0]        wrData_q;
    logic [RW-1:0]                rdOff_q;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]        dqOut_q;
    logic                         dqOe_q;
    logic                         weN_q;
    logic                         oeN_q;
    logic                         ceN_q;
    logic                         bytesN_q;
    logic [DATA_WIDTH-1:0]        dataOut_q;
    logic                         finish_q;
    logic                         busy_q;

    logic                         wrReq_d;
    logic                         rdReq_d;
    logic [DATA_WIDTH-1:0]        wrData_d;
    logic [RW-1:0]                rdOff_d;
    logic [RW-1:0]                wptrInc_d;
    logic [RW-1:0]                rdAddr_d;
    logic                         unusedOffsetLsb;

    // A strobe arriving this cycle counts as pending so an idle FSM starts at once.
    assign wrReq_d   = wr | wrPend_q;
    assign rdReq_d   = rd | rdPend_q;
    assign wrData_d  = wr ? data_in : wrData_q;
    assign rdOff_d   = rd ? offset[ADDR_WIDTH-1:1] : rdOff_q;
    assign wptrInc_d = wptr_q + RW'(1);
    assign rdAddr_d  = wptr_q - rdOff_d;
    assign unusedOffsetLsb = offset[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wptr_q    <= '1;
            wrPend_q  <= 1'b0;
            rdPend_q  <= 1'b0;
            wrData_q  <= '0;
            rdOff_q   <= '0;
            addr_q    <= '0;
            dqOut_q   <= '0;
            dqOe_q    <= 1'b0;
            weN_q     <= 1'b1;
            oeN_q     <= 1'b1;
            ceN_q     <= 1'b1;
            bytesN_q  <= 1'b1;
            dataOut_q <= '0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (wr) begin
                wrPend_q <= 1'b1;
                wrData_q <= data_in;
            end
            if (rd) begin
                rdPend_q <= 1'b1;
                rdOff_q  <= offset[ADDR_WIDTH-1:1];
            end
            case (state_q)
                IDLE: begin
                    // Writes win so a simultaneous read sees the freshly advanced head.
                    if (wrReq_d) begin
                        state_q  <= WRITE;
                        cnt_q    <= CW'(1);
                        wrPend_q <= 1'b0;
                        wptr_q   <= wptrInc_d;
                        addr_q   <= SRAM_ADDR_WIDTH'(wptrInc_d);
                        dqOut_q  <= wrData_d;
                        dqOe_q   <= 1'b1;
                        ceN_q    <= 1'b0;
                        bytesN_q <= 1'b0;
                        oeN_q    <= 1'b1;
                        weN_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (rdReq_d) begin
                        state_q  <= READ;
                        cnt_q    <= CW'(1);
                        rdPend_q <= 1'b0;
                        addr_q   <= SRAM_ADDR_WIDTH'(rdAddr_d);
                        dqOe_q   <= 1'b0;
                        ceN_q    <= 1'b0;
                        bytesN_q <= 1'b0;
                        oeN_q    <= 1'b0;
                        weN_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= IDLE;
                        dqOe_q   <= 1'b0;
                        ceN_q    <= 1'b1;
                        bytesN_q <= 1'b1;
                        weN_q    <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        // Pulse low for cycles 2..WAIT_CYCLES, leaving one setup and one hold cycle.
                        weN_q <= (cnt_q >= WE_END);
                    end
                end
                READ: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= FINISH;
                        dataOut_q <= SRAM_DQ;
                        finish_q  <= 1'b1;
                        ceN_q     <= 1'b1;
                        bytesN_q  <= 1'b1;
                        oeN_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FINISH: begin
                    state_q  <= IDLE;
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out    = dataOut_q;
    assign read_finish = finish_q;
    assign busy        = busy_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_WE_N   = weN_q;
    assign SRAM_OE_N   = oeN_q;
    assign SRAM_CE_N   = ceN_q;
    assign SRAM_UB_N   = bytesN_q;
    assign SRAM_LB_N   = bytesN_q;
    assign SRAM_DQ     = dqOe_q ? dqOut_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_delay_sram_ctrl.sv
// Scoreboard bench for delay_sram_ctrl with an SRAM model and a ring reference model.
// Expected read data comes from a plain array + head index kept in the bench.
module tb_delay_sram_ctrl;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [15:0] dataIn;
    logic [12:0] offset;
    logic [15:0] dataOut;
    logic        readFinish;
    logic        busy;
    logic [17:0] sramAddr;
    wire  [15:0] sramDq;
    logic        weN, oeN, ceN, ubN, lbN;

    typedef struct {
        logic [15:0] data;
        int          cycle;
    } exp_t;

    exp_t        expQ[$];
    int          errors = 0;
    int          checks = 0;
    int          cycleCnt = 0;
    logic [15:0] sramMem [0:DEPTH-1];
    logic [15:0] refMem  [0:DEPTH-1];
    int          refPtr;

    delay_sram_ctrl dut (
        .clk(clk), .rst(rst), .wr(wr), .data_in(dataIn), .rd(rd), .offset(offset),
        .data_out(dataOut), .read_finish(readFinish), .busy(busy),
        .SRAM_ADDR(sramAddr), .SRAM_DQ(sramDq), .SRAM_WE_N(weN), .SRAM_OE_N(oeN),
        .SRAM_CE_N(ceN), .SRAM_UB_N(ubN), .SRAM_LB_N(lbN)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives the bus while output-enabled, stores while write-enabled.
    assign sramDq = (!ceN && !oeN && weN) ? sramMem[sramAddr[11:0]] : 16'hzzzz;

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (!ceN && !weN && !ubN && !lbN)
            sramMem[sramAddr[11:0]] <= sramDq;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cycleCnt);
        end
    endtask

    // Monitor: pops the scoreboard on every read_finish and checks bus discipline.
    always @(negedge clk) begin
        if (!rst && readFinish) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_finish: data %0h with no read outstanding", dataOut);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (dataOut !== e.data || cycleCnt != e.cycle) begin
                    errors++;
                    $display("[TB] FAIL read_result: got %0h at cycle %0d, expected %0h at cycle %0d",
                             dataOut, cycleCnt, e.data, e.cycle);
                end
            end
        end
        if (!rst && !weN) begin
            checks++;
            if (sramAddr >= 18'(DEPTH) || ceN || !oeN || $isunknown(sramDq)) begin
                errors++;
                $display("[TB] FAIL write_pulse: addr %0h ce %0b oe %0b dq %0h", sramAddr, ceN, oeN, sramDq);
            end
        end
        if (!rst && !oeN) begin
            checks++;
            if (!weN || ceN || $isunknown(sramDq)) begin
                errors++;
                $display("[TB] FAIL read_bus: we %0b ce %0b dq %0h", weN, ceN, sramDq);
            end
        end
    end

    function automatic void refWrite(input logic [15:0] v);
        refPtr = (refPtr + 1) % DEPTH;
        refMem[refPtr] = v;
    endfunction

    function automatic logic [15:0] refRead(input logic [12:0] off);
        return refMem[(refPtr - int'(off >> 1) + DEPTH) % DEPTH];
    endfunction

    // Issues one access from an idle DUT and waits until it and any queued read are done.
    task automatic applyStimulus(input bit doWr, input logic [15:0] val, input bit doRd,
                                 input logic [12:0] off, output logic [15:0] expData);
        bit done;
        expData = '0;
        if (doWr) refWrite(val);
        if (doRd) begin
            exp_t e;
            expData = refRead(off);
            e.data  = expData;
            e.cycle = cycleCnt + (doWr ? 8 : 4);
            expQ.push_back(e);
        end
        wr = doWr; rd = doRd; dataIn = val; offset = off;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        checkOutput("busy_after_strobe", 32'(busy), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!busy && expQ.size() == 0) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checkOutput("access_timeout", 32'(done), 32'd1);
        if (!done) expQ.delete();
        if (doRd && done) checkOutput("data_held", 32'(dataOut), 32'(expData));
    endtask

    task automatic doReset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        refPtr = DEPTH - 1;
    endtask

    logic [15:0] got;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sramMem[i] = '0;
            refMem[i]  = '0;
        end
        dataIn = '0; offset = '0;
        doReset();

        for (int i = 0; i < 20; i++) begin
            checkOutput("idle_ctrl", {27'd0, weN, oeN, ceN, ubN, lbN}, 32'h1f);
            checkOutput("idle_state", {busy, readFinish, 14'd0, dataOut}, 32'd0);
            checkOutput("idle_dq", 32'(sramDq === 16'hzzzz), 32'd1);
            @(posedge clk); #1;
        end
        checkOutput("reset_addr", 32'(sramAddr), 32'd0);

        applyStimulus(1'b1, 16'h1234, 1'b0, 13'd0, got);
        checkOutput("word0_after_write", 32'(sramMem[0]), 32'h1234);
        applyStimulus(1'b0, 16'h0, 1'b1, 13'd0, got);
        checkOutput("read_newest", 32'(dataOut), 32'h1234);

        for (int v = 1; v <= 100; v++) applyStimulus(1'b1, 16'(v), 1'b0, 13'd0, got);
        applyStimulus(1'b0, 16'h0, 1'b1, 13'd20, got);
        checkOutput("offset20", 32'(dataOut), 32'd90);
        applyStimulus(1'b0, 16'h0, 1'b1, 13'd21, got);
        checkOutput("offset21", 32'(dataOut), 32'd90);

        applyStimulus(1'b1, 16'hBEEF, 1'b1, 13'd0, got);
        checkOutput("wr_rd_same_cycle", 32'(dataOut), 32'hBEEF);

        doReset();
        for (int v = 0; v < 4100; v++) applyStimulus(1'b1, 16'(v), 1'b0, 13'd0, got);
        checkOutput("wrap_last_addr", 32'(sramAddr), 32'd3);
        applyStimulus(1'b0, 16'h0, 1'b1, 13'd8, got);
        checkOutput("wrap_read", 32'(dataOut), 32'd4095);

        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            applyStimulus(kind != 1, 16'($urandom), kind != 0, 13'($urandom_range(0, 8191)), got);
        end

        rd = 1'b1; offset = 13'd2;
        @(posedge clk); #1;
        rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_mid_read", {29'd0, oeN, busy, readFinish}, 32'h4);
        rst = 1'b0;
        refPtr = DEPTH - 1;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'hA5C3, 1'b0, 13'd0, got);
        checkOutput("post_reset_word0", 32'(sramMem[0]), 32'hA5C3);
        applyStimulus(1'b0, 16'h0, 1'b1, 13'd0, got);
        checkOutput("post_reset_read", 32'(dataOut), 32'hA5C3);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
